instruction_fetcher: RTL
========================

# instruction_fetcher

- Fetch stage between the program counter and the decoder/issue logic.
- Each cycle it looks up the current PC in the instruction cache.
- On a hit, it registers the instruction for the decoder under a valid/stall handshake.
- On a miss, it requests the word from the memory controller and writes it into the cache when the word returns.
- A flush redirects the PC on branch mispredict or exception; an in-flight memory miss is drained safely.

## Interface
- RESET_PC, 32'h0, PC loaded on reset.
- clk_in  in  1  clock; all state updates on rising edge.
- rst_in  in  1  reset; one clock, reset is synchronous and active-high.
- rdy_in  in  1  global enable; low freezes all state.
- ic_addr  out  32  cache lookup/write address; bits [1:0] always 0.
- ic_hit  in  1  cache hit for ic_addr (combinational).
- ic_res  in  32  cached word for ic_addr.
- ic_we  out  1  cache write strobe.
- ic_data  out  32  word to write.
- mem_req  out  1  memory read request, level, held until mem_done.
- mem_addr  out  32  word address of request.
- mem_done  in  1  one-cycle pulse, mem_data valid.
- mem_data  in  32  returned word.
- stall_in  in  1  decoder cannot accept this cycle.
- flush_in  in  1  redirect request.
- flush_pc  in  32  redirect target, word aligned.
- inst_valid  out  1  instruction slot occupied.
- inst  out  32  instruction word.
- inst_pc  out  32  address of inst.
- inst_pred_pc  out  32  predicted next PC for inst.

## Operation
- Registers: pc, state ∈ {FETCH, MISS, DRAIN}, miss_addr, output slot (inst_valid, inst, inst_pc, inst_pred_pc).
- Slot free when !inst_valid || !stall_in. Transfer occurs on a cycle with inst_valid && !stall_in.
- ic_addr = miss_addr in DRAIN; otherwise ic_addr = pc. ic_data = mem_data.
- ic_we = rdy_in && mem_done && state ∈ {MISS, DRAIN}.
- mem_req = state ∈ {MISS, DRAIN}. mem_addr = miss_addr.

FETCH:
- Hit and slot free: load the slot with ic_res, pc, and next_pc; then pc <= next_pc. next_pc = pc+4 unless predicted (see Configuration).
- Hit with slot not free: hold everything.
- Miss: miss_addr <= pc; go to MISS. Any valid slot content stays and obeys the handshake.
- If the slot was consumed and no new load occurs, inst_valid <= 0.

MISS:
- Wait for mem_done.
- On mem_done: cache written at miss_addr; go to FETCH. The next FETCH lookup hits.

DRAIN:
- Entered only by a flush while in MISS.
- On mem_done: cache written at miss_addr with the returned word; go to FETCH.

Flush (flush_in && rdy_in) has highest priority:
- pc <= flush_pc; inst_valid <= 0.
- State becomes FETCH, except from MISS/DRAIN without a same-cycle mem_done, where it becomes DRAIN.
- A flush in the same cycle as mem_done still writes the cache and goes to FETCH.
- Flush suppresses any same-cycle slot load.

Reset:
- pc = RESET_PC, state FETCH, miss_addr 0.
- inst_valid, inst, inst_pc, inst_pred_pc all 0.
- mem_req 0, ic_we 0.
- Reset mid-miss abandons the request. The memory controller is reset by the same rst_in.

rdy_in low: no register changes; ic_we forced 0; mem_req keeps its current level.

## Timing
- Hit: lookup in cycle N, inst_valid high in N+1. Sustains 1 instruction/cycle while stall_in is low.
- Miss detected in N: mem_req high from N+1 through the mem_done cycle M; cache write at M; hit lookup at M+1; inst_valid at M+2.
- Flush in cycle F: first lookup of flush_pc in F+1 (if not draining); no slot valid in F+1.
- pc wraps modulo 2^32; 32'hFFFFFFFC + 4 = 0.

## Configuration
- JAL_PREDICT_EN defined: when a loaded instruction has inst[6:0] = 7'b1101111, next_pc = pc + sign-extended J-immediate {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}. inst_pred_pc carries the same value.
- Undefined: next_pc = pc+4 always; inst_pred_pc = inst_pc+4.

## Test plan
- Reset, memory preloaded with 0x00000013 at 0x0, 4, 8, 5-cycle memory latency, stall_in 0 -> three misses to 0x0/0x4/0x8, each delivering inst_valid 2 cycles after mem_done; refetch after flush_pc=0 hits with back-to-back inst_valid.
- Warm cache, stall_in high for 3 cycles with inst_valid set -> inst, inst_pc held stable; pc unchanged; resume delivers next PC without loss or duplication.
- Flush to 0x100 two cycles into a miss at 0x40 -> mem_req stays high until mem_done; cache then hits at 0x40; no inst_valid for 0x40; next fetched inst_pc = 0x100.
- Flush coinciding with mem_done -> ic_we pulses once at miss_addr; state FETCH; next lookup at flush_pc.
- JAL_PREDICT_EN with 0x0080006F (jal x0,+8) at 0x20 -> inst_pred_pc = 0x28 and next inst_pc = 0x28; undefined -> 0x24.
- rdy_in low for 4 cycles mid-miss, with mem_done held off until rdy_in returns -> no state change; mem_req stays high; completion identical to the rdy_in-always-high run.

Source files
------------

// File: rtl/instruction_fetcher.sv
// instruction_fetcher
//   Fetch stage between the program counter and the decoder. Each cycle the
//   current PC is looked up in the instruction cache. A hit loads the output
//   slot, which follows the valid/stall handshake. A miss requests the word
//   from the memory controller and writes it into the cache on return. A flush
//   redirects the PC. A miss that is in flight when the flush arrives is
//   drained, so the returned word still lands in the cache.
//
//   Optional feature macro: JAL_PREDICT_EN
//     When defined, a loaded JAL (opcode 7'b1101111) redirects next_pc to its
//     jump target. When undefined, next_pc is always pc + 4.
//
//   Ports
//     clk_in, rst_in     clock; synchronous active-high reset
//     rdy_in             global enable; low freezes every register
//     ic_addr/ic_hit/ic_res     cache lookup (combinational hit/data)
//     ic_we/ic_data             cache write of the word returned by memory
//     mem_req/mem_addr          level request, held until mem_done
//     mem_done/mem_data         one-cycle return pulse and data
//     stall_in                  decoder cannot accept this cycle
//     flush_in/flush_pc         redirect request and word-aligned target
//     inst_valid/inst/inst_pc/inst_pred_pc   output slot
//     state_dbg                 current FSM state, for observation only
//
//   Handshake: the slot holds an instruction while inst_valid is high. It
//   transfers on any enabled cycle with inst_valid && !stall_in. The slot may
//   load a new word on a cycle where it is empty or is being transferred.
module instruction_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic [31:0] ic_addr,
  input  logic        ic_hit,
  input  logic [31:0] ic_res,
  output logic        ic_we,
  output logic [31:0] ic_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [31:0] flush_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pred_pc,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    MISS  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] miss_addr;
  logic [31:0] next_pc;
  logic        slot_free;
  logic        slot_taken;
  logic        in_miss;

  assign slot_free  = !inst_valid || !stall_in;
  assign slot_taken = inst_valid && !stall_in;
  assign in_miss    = (state == MISS) || (state == DRAIN);

  // While draining, pc already holds the flush target, so the cache port
  // must point back at the address being refilled.
  assign ic_addr   = (state == DRAIN) ? miss_addr : pc;
  assign ic_data   = mem_data;
  assign ic_we     = rdy_in && mem_done && in_miss;
  assign mem_req   = in_miss;
  assign mem_addr  = miss_addr;
  assign state_dbg = state;

  // Predicted successor of the word at pc. The low two bits are cleared so
  // that the PC, and with it ic_addr, always stays word aligned.
  always_comb begin
    next_pc = pc + 32'd4;
`ifdef JAL_PREDICT_EN
    if (ic_res[6:0] == 7'b1101111) begin
      next_pc = pc + {{11{ic_res[31]}}, ic_res[31], ic_res[19:12],
                      ic_res[20], ic_res[30:21], 1'b0};
    end
`endif
    next_pc = next_pc & 32'hFFFF_FFFC;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc           <= RESET_PC;
      state        <= FETCH;
      miss_addr    <= 32'h0;
      inst_valid   <= 1'b0;
      inst         <= 32'h0;
      inst_pc      <= 32'h0;
      inst_pred_pc <= 32'h0;
    end else if (rdy_in) begin
      if (flush_in) begin
        pc         <= flush_pc & 32'hFFFF_FFFC;
        inst_valid <= 1'b0;
        // An outstanding request cannot be cancelled at the memory
        // controller, so it is drained unless it completes this cycle.
        if (in_miss && !mem_done) state <= DRAIN;
        else                      state <= FETCH;
      end else begin
        case (state)
          FETCH: begin
            if (ic_hit) begin
              if (slot_free) begin
                inst_valid   <= 1'b1;
                inst         <= ic_res;
                inst_pc      <= pc;
                inst_pred_pc <= next_pc;
                pc           <= next_pc;
              end
            end else begin
              miss_addr <= pc;
              state     <= MISS;
              if (slot_taken) inst_valid <= 1'b0;
            end
          end
          MISS, DRAIN: begin
            if (slot_taken) inst_valid <= 1'b0;
            if (mem_done)   state      <= FETCH;
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule
